pixel_stream_receiver: RTL and testbench

Sink end of the Mandelbrot pixel stream. Accepts the r/g/b + first/last_x/last_y + valid/ready stream driven by the pixel generator top and checks its framing against configured frame dimensions. Writes each well-framed pixel into a frame-buffer write port through a 2-entry buffer, resynchronising on framing errors. Sits between the generator top and the frame-buffer/display memory.

---
 rtl/pixel_stream_receiver.sv | 209 ++++++++++++++++++++
 tb/tb_pixel_stream_receiver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_receiver.sv
// pixel_stream_receiver
// Sink end of the pixel stream: checks first/last_x/last_y framing against the
// configured frame size, and queues well-framed pixels into a 2-entry
// fall-through buffer that feeds the frame-buffer write port.
module pixel_stream_receiver #(
    parameter int X_SIZE     = 640,
    parameter int Y_SIZE     = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            r,
    input  logic [7:0]            g,
    input  logic [7:0]            b,
    input  logic                  first,
    input  logic                  last_x,
    input  logic                  last_y,
    input  logic                  valid,
    output logic                  ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [23:0]           mem_wr_data,
    input  logic                  mem_wr_ready,
    output logic                  frame_done,
    output logic                  sync_err,
    output logic [15:0]           frame_count,
    output logic [15:0]           err_count,
    output logic                  in_frame
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    localparam logic [0:0] SEEK   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]            state;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [ADDR_WIDTH-1:0] addr;

    logic [1:0]            count;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [ADDR_WIDTH-1:0] fifo_addr [2];
    logic [23:0]           fifo_data [2];

    logic                  accept;
    logic                  pop;
    logic                  exp_first;
    logic                  exp_last_x;
    logic                  exp_last_y;
    logic                  flags_match;

    logic                  start_frame;
    logic                  advance;
    logic                  resync;
    logic                  err;
    logic                  push;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [XW-1:0]         base_x;
    logic [YW-1:0]         base_y;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  base_last_x;
    logic                  base_last_y;
    logic                  frame_end;

    logic [0:0]            state_next;
    logic [XW-1:0]         x_next;
    logic [YW-1:0]         y_next;
    logic [ADDR_WIDTH-1:0] addr_next;

    // ready depends only on buffer occupancy (and reset), never on valid or mem_wr_ready
    assign ready     = !reset && (count != 2'd2);
    assign accept    = valid && ready;
    assign mem_wr_en = (count != 2'd0);
    assign pop       = mem_wr_en && mem_wr_ready;
    assign in_frame  = (state == ACTIVE);

    // Head of the buffer is only presented while it holds something, so the port idles at zero
    assign mem_wr_addr = mem_wr_en ? fifo_addr[rd_ptr] : '0;
    assign mem_wr_data = mem_wr_en ? fifo_data[rd_ptr] : '0;

    assign exp_first   = (x == '0) && (y == '0);
    assign exp_last_x  = (x == X_LAST);
    assign exp_last_y  = exp_last_x && (y == Y_LAST);
    assign flags_match = (first == exp_first) && (last_x == exp_last_x) && (last_y == exp_last_y);

    // Classify the accepted beat: frame start, in-order pixel, or framing error
    always_comb begin
        start_frame = 1'b0;
        advance     = 1'b0;
        resync      = 1'b0;
        err         = 1'b0;
        if (accept) begin
            if (state == SEEK) begin
                start_frame = first;
            end else if (flags_match) begin
                advance = 1'b1;
            end else begin
                err = 1'b1;
                if (first) begin
                    start_frame = 1'b1;
                end else begin
                    resync = 1'b1;
                end
            end
        end
    end

    // A frame start restarts the position from (0,0) before stepping, like any in-order pixel
    always_comb begin
        push        = start_frame || advance;
        base_x      = start_frame ? '0 : x;
        base_y      = start_frame ? '0 : y;
        base_addr   = start_frame ? '0 : addr;
        push_addr   = base_addr;
        base_last_x = (base_x == X_LAST);
        base_last_y = base_last_x && (base_y == Y_LAST);
        frame_end   = push && base_last_y;
    end

    // Next position/address and FSM state; running address replaces any y*X_SIZE multiply
    always_comb begin
        state_next = state;
        x_next     = x;
        y_next     = y;
        addr_next  = addr;
        if (push) begin
            state_next = ACTIVE;
            if (base_last_y) begin
                x_next    = '0;
                y_next    = '0;
                addr_next = '0;
            end else if (base_last_x) begin
                x_next    = '0;
                y_next    = base_y + YW'(1);
                addr_next = base_addr + ADDR_WIDTH'(1);
            end else begin
                x_next    = base_x + XW'(1);
                addr_next = base_addr + ADDR_WIDTH'(1);
            end
        end else if (resync) begin
            state_next = SEEK;
            x_next     = '0;
            y_next     = '0;
            addr_next  = '0;
        end
    end

    // Framing state, position counters, status pulses and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEEK;
            x           <= '0;
            y           <= '0;
            addr        <= '0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            state      <= state_next;
            x          <= x_next;
            y          <= y_next;
            addr       <= addr_next;
            frame_done <= frame_end;
            sync_err   <= err;
            if (frame_end) begin
                frame_count <= frame_count + 16'd1;
            end
            if (err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    // Buffer pointers and occupancy; simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage needs no reset; occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_data[wr_ptr] <= {b, g, r};
        end
    end

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// tb_pixel_stream_receiver
// Directed framing scenarios followed by randomized frames with flag corruption
// and write backpressure, scored against a linear-index reference model.
module tb_pixel_stream_receiver;

    localparam int XS     = 4;
    localparam int YS     = 3;
    localparam int TOTAL  = XS * YS;
    localparam int AW     = 19;
    localparam int LIMIT  = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    r, g, b;
    logic          first, last_x, last_y, valid;
    logic          ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [23:0]   mem_wr_data;
    logic          mem_wr_ready;
    logic          frame_done, sync_err;
    logic [15:0]   frame_count, err_count;
    logic          in_frame;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    logic [AW+23:0] q[$];
    bit             synced = 1'b0;
    int             pos = 0;
    logic [15:0]    m_fc = '0;
    logic [15:0]    m_ec = '0;
    bit             fd_e = 1'b0;
    bit             se_e = 1'b0;
    bit             mon_on = 1'b0;
    bit             rand_bp = 1'b0;
    int             wr_seen = 0;
    int             fd_seen = 0;
    int             se_seen = 0;
    bit             stall_prev = 1'b0;
    logic [AW-1:0]  prev_addr;
    logic [23:0]    prev_data;

    pixel_stream_receiver #(.X_SIZE(XS), .Y_SIZE(YS), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .r(r), .g(g), .b(b),
        .first(first), .last_x(last_x), .last_y(last_y), .valid(valid), .ready(ready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ready(mem_wr_ready), .frame_done(frame_done), .sync_err(sync_err),
        .frame_count(frame_count), .err_count(err_count), .in_frame(in_frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int a, input logic [23:0] d);
        q.push_back({AW'(a), d});
        pos = a + 1;
        synced = 1'b1;
        if (pos == TOTAL) begin
            pos  = 0;
            fd_e = 1'b1;
            m_fc = m_fc + 16'd1;
        end
    endtask

    task automatic model_beat(input logic f, input logic lx, input logic ly, input logic [23:0] d);
        if (!synced) begin
            if (f) model_write(0, d);
        end else if (f == (pos == 0) && lx == ((pos % XS) == XS - 1) && ly == (pos == TOTAL - 1)) begin
            model_write(pos, d);
        end else begin
            se_e = 1'b1;
            if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
            if (f) begin
                model_write(0, d);
            end else begin
                pos    = 0;
                synced = 1'b0;
            end
        end
    endtask

    // Per-cycle scoreboard: compare outputs to the model, then step the model for the coming edge
    always @(negedge clk) begin
        if (mon_on) begin
            check("ready", ready, !reset && (q.size() < 2));
            check("wr_en", mem_wr_en, q.size() != 0);
            if (mem_wr_en && q.size() != 0) begin
                check("wr_addr", mem_wr_addr, q[0][AW+23:24]);
                check("wr_data", mem_wr_data, q[0][23:0]);
            end
            if (stall_prev && mem_wr_en) begin
                check("stall_addr", mem_wr_addr, prev_addr);
                check("stall_data", mem_wr_data, prev_data);
            end
            check("frame_done", frame_done, fd_e);
            check("sync_err", sync_err, se_e);
            check("frame_count", frame_count, m_fc);
            check("err_count", err_count, m_ec);
            check("in_frame", in_frame, synced);
            if (frame_done === 1'b1) fd_seen++;
            if (sync_err === 1'b1) se_seen++;
            stall_prev = mem_wr_en && !mem_wr_ready && !reset;
            prev_addr  = mem_wr_addr;
            prev_data  = mem_wr_data;

            fd_e = 1'b0;
            se_e = 1'b0;
            if (reset) begin
                q.delete();
                synced = 1'b0;
                pos    = 0;
                m_fc   = '0;
                m_ec   = '0;
            end else begin
                if (mem_wr_en && mem_wr_ready && q.size() != 0) begin
                    void'(q.pop_front());
                    wr_seen++;
                end
                if (valid && ready) model_beat(first, last_x, last_y, {b, g, r});
            end
        end
    end

    task automatic bp_step();
        if (rand_bp) mem_wr_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic f, input logic lx, input logic ly);
        int waited = 0;
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        first = f; last_x = lx; last_y = ly; valid = 1'b1;
        forever begin
            @(negedge clk);
            if (ready) break;
            if (waited == LIMIT) begin
                compared++;
                mismatched++;
                $error("FAIL accept_timeout: observed=%0d expected<%0d", waited, LIMIT);
                break;
            end
            waited++;
            @(posedge clk); #1;
            bp_step();
        end
        @(posedge clk); #1;
        valid = 1'b0;
        bp_step();
    endtask

    task automatic send_at(input int p);
        send_beat(p == 0, (p % XS) == XS - 1, p == TOTAL - 1);
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            bp_step();
        end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; first = 1'b0; last_x = 1'b0; last_y = 1'b0;
        r = '0; g = '0; b = '0; mem_wr_ready = 1'b1;
        @(posedge clk); #1;
        mon_on = 1'b1;
        @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_wr_addr", mem_wr_addr, 0);
        check("rst_wr_data", mem_wr_data, 0);
        check("rst_in_frame", in_frame, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // junk before any frame start
        repeat (3) send_beat(1'b0, 1'b0, 1'b0);
        idle(3);
        check("junk_writes", wr_seen, 0);
        check("junk_err", err_count, 0);

        // clean frame at full throughput
        for (int p = 0; p < TOTAL; p++) send_at(p);
        idle(4);
        check("clean_writes", wr_seen, 12);
        check("clean_fd", fd_seen, 1);
        check("clean_se", se_seen, 0);
        check("clean_fc", frame_count, 1);

        // backpressure: write port stalled for 5 cycles after the first beat
        mem_wr_ready = 1'b0;
        send_at(0);
        fork
            begin
                repeat (5) @(posedge clk);
                #1 mem_wr_ready = 1'b1;
            end
        join_none
        send_at(1);
        @(negedge clk);
        check("bp_full_ready", ready, 0);
        check("bp_head_addr", mem_wr_addr, 0);
        @(posedge clk); #1;
        for (int p = 2; p < TOTAL; p++) send_at(p);
        idle(4);
        check("bp_writes", wr_seen, 24);
        check("bp_fc", frame_count, 2);

        // last_x missing at x=3,y=0, then non-first beats are dropped
        for (int p = 0; p < 3; p++) send_at(p);
        send_beat(1'b0, 1'b0, 1'b0);
        idle(2);
        check("lx_err", err_count, 1);
        check("lx_in_frame", in_frame, 0);
        check("lx_writes", wr_seen, 27);
        send_at(4);
        send_at(5);
        idle(2);
        check("lx_drop_writes", wr_seen, 27);

        // unexpected first at x=2,y=1 restarts the frame at address 0
        for (int p = 0; p < 6; p++) send_at(p);
        send_beat(1'b1, 1'b0, 1'b0);
        send_at(1);
        idle(3);
        check("mid_in_frame", in_frame, 1);
        check("mid_err", err_count, 2);
        check("mid_se", se_seen, 2);
        check("mid_writes", wr_seen, 35);

        // reset with two entries buffered mid-frame
        mem_wr_ready = 1'b0;
        send_at(2);
        send_at(3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mem_wr_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_wr_en", mem_wr_en, 0);
        check("rst_mid_in_frame", in_frame, 0);
        check("rst_mid_fc", frame_count, 0);
        @(posedge clk); #1;
        send_beat(1'b0, 1'b0, 1'b0);
        idle(2);
        check("rst_mid_writes", wr_seen, 35);
        check("rst_mid_err", err_count, 0);

        // randomized frames with occasional flag corruption, junk and backpressure
        rand_bp = 1'b1;
        for (int fr = 0; fr < 8; fr++) begin
            for (int p = 0; p < TOTAL; p++) begin
                logic f, lx, ly;
                int sel;
                f  = (p == 0);
                lx = (p % XS) == XS - 1;
                ly = (p == TOTAL - 1);
                if ($urandom_range(0, 19) == 0) begin
                    sel = $urandom_range(0, 2);
                    if (sel == 0) f = ~f;
                    else if (sel == 1) lx = ~lx;
                    else ly = ~ly;
                end
                if ($urandom_range(0, 29) == 0) send_beat(1'b0, 1'b0, 1'b0);
                send_beat(f, lx, ly);
            end
        end
        rand_bp = 1'b0;
        mem_wr_ready = 1'b1;
        idle(6);
        check("drain_wr_en", mem_wr_en, 0);
        check("drain_fc", frame_count, m_fc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
